mem_trace_lockstep_cmp: RTL and testbench

//  Compares the memory-access streams of NUM_CH CPU instances running the same program in lockstep-equivalence checks.

---
 rtl/mem_trace_lockstep_cmp.sv | 154 +++++++++++++++
 tb/tb_mem_trace_lockstep_cmp.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_trace_lockstep_cmp.sv
// Passive lockstep monitor: queues every accepted memory access per channel and compares
// the Nth access of each channel against the Nth access of channel 0.
module mem_trace_lockstep_cmp #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int CMP_WDATA = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CH-1:0]               ch_valid,
  input  logic [NUM_CH-1:0]               ch_ready,
  input  logic [NUM_CH-1:0]               ch_instr,
  input  logic [NUM_CH*ADDR_W-1:0]        ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]        ch_wdata,
  input  logic [NUM_CH*(DATA_W/8)-1:0]    ch_wstrb,
  output logic                            mismatch,
  output logic [$clog2(NUM_CH)-1:0]       mismatch_ch,
  output logic [31:0]                     mismatch_idx,
  output logic                            overflow,
  output logic [31:0]                     cmp_count,
  output logic                            busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int KEY_W  = 1 + ADDR_W;
  localparam int ENT_W  = KEY_W + STRB_W + DATA_W;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MISMATCH = 2'd1,
    S_OVERFLOW = 2'd2
  } state_t;

  state_t            state;
  logic [ENT_W-1:0]  mem     [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  rd_ptr  [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr  [NUM_CH];
  logic [OCC_W-1:0]  occ     [NUM_CH];
  logic [OCC_W-1:0]  occ_next[NUM_CH];
  logic [ENT_W-1:0]  wr_entry[NUM_CH];
  logic [ENT_W-1:0]  head    [NUM_CH];

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] write;
  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] differ;
  logic              run;
  logic              pop;
  logic              any_diff;
  logic              any_drop;
  logic              busy_next;
  logic [CH_W-1:0]   diff_ch;

  // Bytes not enabled by the strobe carry no meaning and must never cause a divergence.
  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [STRB_W-1:0] s);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < STRB_W; b++) m[b*8 +: 8] = d[b*8 +: 8] & {8{s[b]}};
    return m;
  endfunction

  function automatic logic entry_eq(input logic [ENT_W-1:0] x, input logic [ENT_W-1:0] y);
    if (CMP_WDATA != 0) return x == y;
    return x[ENT_W-1 -: KEY_W] == y[ENT_W-1 -: KEY_W];
  endfunction

  always_comb begin
    run = (state == S_RUN);
    for (int k = 0; k < NUM_CH; k++) begin
      nonempty[k] = (occ[k] != '0);
      full[k]     = (occ[k] == OCC_W'(DEPTH));
      head[k]     = mem[k][rd_ptr[k]];
      wr_entry[k] = {ch_instr[k], ch_addr[k*ADDR_W +: ADDR_W], ch_wstrb[k*STRB_W +: STRB_W],
                     mask_bytes(ch_wdata[k*DATA_W +: DATA_W], ch_wstrb[k*STRB_W +: STRB_W])};
    end
    // Heads pop together only when every queue holds an entry as of the last edge.
    pop = run && (&nonempty);
    for (int k = 0; k < NUM_CH; k++) begin
      push[k]     = run && ch_valid[k] && ch_ready[k];
      drop[k]     = push[k] && full[k] && !pop;
      write[k]    = push[k] && !drop[k];
      differ[k]   = (k != 0) && !entry_eq(head[k], head[0]);
      occ_next[k] = occ[k] + OCC_W'(write[k]) - OCC_W'(pop);
    end
    any_diff = pop && (|differ);
    any_drop = |drop;
    diff_ch  = '0;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      if (differ[k]) diff_ch = CH_W'(k);
    end
    busy_next = 1'b0;
    for (int k = 0; k < NUM_CH; k++) busy_next = busy_next | (occ_next[k] != '0);
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (write[k]) mem[k][wr_ptr[k]] <= wr_entry[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_RUN;
      mismatch     <= 1'b0;
      mismatch_ch  <= '0;
      mismatch_idx <= '0;
      overflow     <= 1'b0;
      cmp_count    <= '0;
      busy         <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        rd_ptr[k] <= '0;
        wr_ptr[k] <= '0;
        occ[k]    <= '0;
      end
    end else if (run) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (pop)      rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
        if (write[k]) wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        occ[k] <= occ_next[k];
      end
      busy <= busy_next;
      if (any_diff) begin
        state        <= S_MISMATCH;
        mismatch     <= 1'b1;
        mismatch_ch  <= diff_ch;
        mismatch_idx <= cmp_count;
      end else if (pop) begin
        cmp_count <= cmp_count + 32'd1;
      end
      // A divergence in the same cycle as a drop is the more useful diagnosis, so it owns the state.
      if (any_drop) begin
        overflow <= 1'b1;
        if (!any_diff) state <= S_OVERFLOW;
      end
    end
  end

  a_count_monotonic: assert property (@(posedge clock) disable iff (reset)
    (state == S_RUN) |=> ((cmp_count - $past(cmp_count)) <= 32'd1));

  for (genvar g = 0; g < NUM_CH; g++) begin : g_occ_chk
    a_occ_bound: assert property (@(posedge clock) disable iff (reset) occ[g] <= OCC_W'(DEPTH));
  end

  c_mismatch_reached: cover property (@(posedge clock) state == S_MISMATCH);

endmodule

// File: tb/tb_mem_trace_lockstep_cmp.sv
// Bench for mem_trace_lockstep_cmp: 2-channel and 3-channel instances, directed scenarios
// plus randomized lockstep programs, all checked against a queue-based reference model.
module tb_mem_trace_lockstep_cmp;

  localparam int DEPTH = 4;
  localparam int PLEN  = 24;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        v   [3];
  logic        r   [3];
  logic        ins [3];
  logic [31:0] a   [3];
  logic [31:0] wd  [3];
  logic [3:0]  ws  [3];

  logic        reset2, reset3;
  logic [1:0]  v2, r2, i2;
  logic [2:0]  v3, r3, i3;
  logic        m2, ov2, b2, m3, ov3, b3;
  logic [0:0]  mc2;
  logic [1:0]  mc3;
  logic [31:0] idx2, cnt2, idx3, cnt3;

  assign reset2 = rst | sel;
  assign reset3 = rst | !sel;
  assign v2 = sel ? 2'b00 : {v[1], v[0]};
  assign r2 = {r[1], r[0]};
  assign i2 = {ins[1], ins[0]};
  assign v3 = sel ? {v[2], v[1], v[0]} : 3'b000;
  assign r3 = {r[2], r[1], r[0]};
  assign i3 = {ins[2], ins[1], ins[0]};

  mem_trace_lockstep_cmp #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .CMP_WDATA(1)) u2 (
    .clock(clock), .reset(reset2), .ch_valid(v2), .ch_ready(r2), .ch_instr(i2),
    .ch_addr({a[1], a[0]}), .ch_wdata({wd[1], wd[0]}), .ch_wstrb({ws[1], ws[0]}),
    .mismatch(m2), .mismatch_ch(mc2), .mismatch_idx(idx2), .overflow(ov2),
    .cmp_count(cnt2), .busy(b2));

  mem_trace_lockstep_cmp #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .CMP_WDATA(1)) u3 (
    .clock(clock), .reset(reset3), .ch_valid(v3), .ch_ready(r3), .ch_instr(i3),
    .ch_addr({a[2], a[1], a[0]}), .ch_wdata({wd[2], wd[1], wd[0]}), .ch_wstrb({ws[2], ws[1], ws[0]}),
    .mismatch(m3), .mismatch_ch(mc3), .mismatch_idx(idx3), .overflow(ov3),
    .cmp_count(cnt3), .busy(b3));

  logic        o_mis, o_ovf, o_busy;
  logic [31:0] o_ch, o_idx, o_cnt;
  assign o_mis  = sel ? m3 : m2;
  assign o_ovf  = sel ? ov3 : ov2;
  assign o_busy = sel ? b3 : b2;
  assign o_ch   = sel ? 32'(mc3) : 32'(mc2);
  assign o_idx  = sel ? idx3 : idx2;
  assign o_cnt  = sel ? cnt3 : cnt2;

  // Reference model: one queue of access tuples per channel, run-state as a small integer.
  logic [68:0] q [3][$];
  int          m_state;
  logic        m_mis, m_ovf, m_busy;
  logic [31:0] m_ch, m_idx, m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [68:0] entry(int k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = ws[k][b] ? wd[k][b*8 +: 8] : 8'h00;
    return {ins[k], a[k], ws[k], m};
  endfunction

  task automatic model_edge();
    int  n;
    int  dk;
    bit  pop;
    bit  dropped;
    n = sel ? 3 : 2;
    if (rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
      m_state = 0; m_mis = 0; m_ovf = 0; m_busy = 0;
      m_ch = 0; m_idx = 0; m_cnt = 0;
      return;
    end
    if (m_state != 0) return;
    pop = 1;
    for (int k = 0; k < n; k++) if (q[k].size() == 0) pop = 0;
    dk = -1;
    if (pop) for (int k = 1; k < n; k++) if (dk < 0 && q[k][0] != q[0][0]) dk = k;
    dropped = 0;
    for (int k = 0; k < n; k++) if (v[k] && r[k] && q[k].size() == DEPTH && !pop) dropped = 1;
    if (pop) for (int k = 0; k < n; k++) void'(q[k].pop_front());
    for (int k = 0; k < n; k++) if (v[k] && r[k] && q[k].size() < DEPTH) q[k].push_back(entry(k));
    if (pop) begin
      if (dk >= 0) begin
        m_state = 1; m_mis = 1; m_ch = dk; m_idx = m_cnt;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    if (dropped) begin
      m_ovf = 1;
      if (dk < 0) m_state = 2;
    end
    m_busy = 0;
    for (int k = 0; k < n; k++) if (q[k].size() != 0) m_busy = 1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ":mismatch"}, 32'(o_mis), 32'(m_mis));
    check({tag, ":overflow"}, 32'(o_ovf), 32'(m_ovf));
    check({tag, ":busy"}, 32'(o_busy), 32'(m_busy));
    check({tag, ":cmp_count"}, o_cnt, m_cnt);
    if (m_mis) begin
      check({tag, ":mismatch_ch"}, o_ch, m_ch);
      check({tag, ":mismatch_idx"}, o_idx, m_idx);
    end
  endtask

  task automatic step(string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      v[k] = 0; r[k] = 1; ins[k] = 0; a[k] = 0; wd[k] = 0; ws[k] = 0;
    end
  endtask

  task automatic acc(int k, logic [31:0] addr, logic [31:0] data, logic [3:0] strb);
    v[k] = 1; r[k] = 1; ins[k] = 0; a[k] = addr; wd[k] = data; ws[k] = strb;
  endtask

  task automatic do_reset(logic s);
    idle();
    rst = 1; sel = s;
    step("reset");
    rst = 0;
  endtask

  logic [31:0] pa [PLEN];
  logic [31:0] pd [PLEN];
  logic [3:0]  ps [PLEN];
  logic        pi [PLEN];
  int          pidx [3];

  initial begin
    logic [31:0] d;
    int          ck, ci, n;
    idle();

    // Reset state
    do_reset(0);
    check("rst_mismatch", 32'(o_mis), 32'd0);
    check("rst_overflow", 32'(o_ovf), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cmp_count", o_cnt, 32'd0);
    check("rst_mismatch_idx", o_idx, 32'd0);

    // Same-cycle accepts on both channels
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      acc(0, 32'h100 + 32'(4 * i), d, 4'hF);
      acc(1, 32'h100 + 32'(4 * i), d, 4'hF);
      step("t1_acc");
    end
    idle();
    step("t1_drain");
    step("t1_drain");
    check("t1_cmp_count", o_cnt, 32'd3);
    check("t1_mismatch", 32'(o_mis), 32'd0);

    // Channel 1 lagging channel 0 by four cycles
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      acc(0, 32'(4 * i), 32'd0, 4'h0);
      step("t2_ch0");
    end
    idle();
    step("t2_gap");
    for (int i = 0; i < 3; i++) begin
      acc(1, 32'(4 * i), 32'd0, 4'h0);
      step("t2_ch1");
    end
    idle();
    step("t2_drain");
    step("t2_drain");
    check("t2_cmp_count", o_cnt, 32'd3);
    check("t2_busy", 32'(o_busy), 32'd0);

    // Divergent address at access index 2
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      acc(0, (i == 2) ? 32'h10 : 32'(4 * i), 32'd0, 4'h0);
      acc(1, (i == 2) ? 32'h14 : 32'(4 * i), 32'd0, 4'h0);
      step("t3_acc");
    end
    idle();
    step("t3_drain");
    step("t3_drain");
    check("t3_mismatch", 32'(o_mis), 32'd1);
    check("t3_mismatch_ch", o_ch, 32'd1);
    check("t3_mismatch_idx", o_idx, 32'd2);
    check("t3_cmp_count", o_cnt, 32'd2);

    // Fifth push into a full queue with channel 1 stalled
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      acc(0, 32'(4 * i), 32'd0, 4'h0);
      v[1] = 1; r[1] = 0;
      step("t4_fill");
      if (i == 3) check("t4_no_ovf_at_4", 32'(o_ovf), 32'd0);
    end
    check("t4_overflow", 32'(o_ovf), 32'd1);
    idle();
    for (int i = 0; i < 5; i++) begin
      acc(1, 32'(4 * i), 32'd0, 4'h0);
      step("t4_ignored");
    end
    check("t4_cmp_count", o_cnt, 32'd0);

    // Push into a full queue while it pops is legal
    do_reset(0);
    for (int i = 0; i < 5; i++) begin
      idle();
      acc(0, 32'(4 * i), 32'd0, 4'h0);
      if (i == 3) acc(1, 32'd0, 32'd0, 4'h0);
      step("t4b_fill");
    end
    check("t4b_no_overflow", 32'(o_ovf), 32'd0);
    idle();
    for (int i = 1; i < 5; i++) begin
      acc(1, 32'(4 * i), 32'd0, 4'h0);
      step("t4b_ch1");
    end
    idle();
    step("t4b_drain");
    step("t4b_drain");
    check("t4b_cmp_count", o_cnt, 32'd5);

    // Masked write bytes ignored, strobe difference detected
    do_reset(0);
    acc(0, 32'h200, 32'hAAAA1234, 4'b0011);
    acc(1, 32'h200, 32'h55551234, 4'b0011);
    step("t5_masked");
    acc(0, 32'h204, 32'h00001234, 4'b0011);
    acc(1, 32'h204, 32'h00001234, 4'b0111);
    step("t5_strb");
    idle();
    step("t5_drain");
    step("t5_drain");
    check("t5_cmp_count", o_cnt, 32'd1);
    check("t5_mismatch", 32'(o_mis), 32'd1);
    check("t5_mismatch_idx", o_idx, 32'd1);

    // Three channels: channel 2 diverges first, then reset mid-stream, then a clean stream
    do_reset(1);
    for (int k = 0; k < 3; k++) acc(k, (k == 2) ? 32'h44 : 32'h40, 32'd0, 4'h0);
    step("t6_acc");
    idle();
    step("t6_drain");
    step("t6_drain");
    check("t6_mismatch_ch", o_ch, 32'd2);
    check("t6_mismatch_idx", o_idx, 32'd0);
    do_reset(1);
    for (int i = 0; i < 2; i++) begin
      acc(0, 32'(4 * i), 32'd0, 4'h0);
      step("t6_partial");
    end
    check("t6_busy_before_reset", 32'(o_busy), 32'd1);
    do_reset(1);
    check("t6_busy_after_reset", 32'(o_busy), 32'd0);
    check("t6_mismatch_cleared", 32'(o_mis), 32'd0);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) acc(k, 32'h80 + 32'(4 * i), 32'd7, 4'h1);
      step("t6_clean");
    end
    idle();
    step("t6_drain2");
    step("t6_drain2");
    check("t6_cmp_count", o_cnt, 32'd3);

    // Randomized lockstep programs with independent per-channel timing
    for (int run = 0; run < 8; run++) begin
      do_reset(logic'(run % 2));
      n = (run % 2) ? 3 : 2;
      for (int i = 0; i < PLEN; i++) begin
        pa[i] = $urandom & 32'hFFFC;
        pd[i] = $urandom;
        ps[i] = 4'($urandom);
        pi[i] = 1'($urandom);
      end
      ck = (run % 4 < 2) ? -1 : 1 + int'($urandom_range(n - 2));
      ci = int'($urandom_range(PLEN - 1));
      for (int k = 0; k < 3; k++) pidx[k] = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
        for (int k = 0; k < 3; k++) begin
          if (pidx[k] < PLEN) begin
            v[k]   = 1'($urandom);
            r[k]   = ($urandom_range(3) != 0);
            ins[k] = pi[pidx[k]];
            a[k]   = pa[pidx[k]];
            wd[k]  = pd[pidx[k]];
            ws[k]  = ps[pidx[k]];
            if (k == ck && pidx[k] == ci) begin
              if (run % 2) a[k] = a[k] ^ 32'h4;
              else ws[k] = ws[k] ^ 4'h8;
            end
          end else begin
            v[k] = 0;
          end
        end
        step("rnd");
        for (int k = 0; k < 3; k++) if (v[k] && r[k]) pidx[k]++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
